// File: rtl/pc_gen_ras.sv
// pc_gen_ras: fetch program-counter generator with a return-address stack.
//
// Produces the registered instruction-fetch address every cycle.
// Redirect sources, highest first:
//   exception vector, resolved branch, predicted return, sequential.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   stall                    freeze pc_out and RAS (exception still acts)
//   exc_valid, exc_vec       exception redirect and its target
//   branch_true, new_addr    resolved-branch redirect and its target
//   call_push                fetch at pc_out is a call: push pc_out+STEP
//   ret_pop                  fetch at pc_out is a return: predict from RAS
//   pc_out                   current fetch address
//   ras_count                number of valid RAS entries
//   ras_overflow             one-cycle pulse: a push overwrote the oldest entry
//   ras_underflow            one-cycle pulse: a pop found the RAS empty
module pc_gen_ras #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       STEP      = 1,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       exc_valid,
  input  logic [ADDR_W-1:0]          exc_vec,
  input  logic                       branch_true,
  input  logic [ADDR_W-1:0]          new_addr,
  input  logic                       call_push,
  input  logic                       ret_pop,
  output logic [ADDR_W-1:0]          pc_out,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_overflow,
  output logic                       ras_underflow
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PtrW-1:0]   top_q, top_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic              ras_we;
  logic [PtrW-1:0]   ras_waddr;
  logic [ADDR_W-1:0] ras_wdata;

  logic [ADDR_W-1:0] pc_seq;
  logic              ras_empty;
  logic              ras_full;

  // Sequential address also serves as the call return address; wraps naturally.
  assign pc_seq    = pc_q + ADDR_W'(STEP);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CntW'(RAS_DEPTH));

  always_comb begin
    pc_d      = pc_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    ras_we    = 1'b0;
    ras_waddr = top_q + PtrW'(1);
    ras_wdata = pc_seq;

    if (exc_valid) begin
      pc_d  = exc_vec;
      cnt_d = '0;
      top_d = '0;
    end else if (!stall) begin
      pc_d = pc_seq;
      if (call_push && ret_pop && !branch_true && !ras_empty) begin
        // Return and call in one fetch: consume the old top and replace it in place.
        pc_d      = ras_q[top_q];
        ras_we    = 1'b1;
        ras_waddr = top_q;
      end else begin
        if (branch_true) begin
          pc_d = new_addr;
        end else if (ret_pop) begin
          if (!ras_empty) begin
            pc_d  = ras_q[top_q];
            top_d = top_q - PtrW'(1);
            cnt_d = cnt_q - CntW'(1);
          end else begin
            unf_d = 1'b1;
          end
        end
        if (call_push) begin
          // When full, the slot after top is the oldest entry, so it gets overwritten.
          ras_we = 1'b1;
          top_d  = top_q + PtrW'(1);
          if (ras_full) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack contents are don't-care after reset; cnt_q gates their validity.
  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras_q[ras_waddr] <= ras_wdata;
    end
  end

  assign pc_out        = pc_q;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
module tb_pc_gen_ras;

  localparam int unsigned AW    = 12;
  localparam logic [AW-1:0] RV  = 12'h100;
  localparam int unsigned STEP  = 4;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, exc_valid, branch_true, call_push, ret_pop;
  logic [AW-1:0] exc_vec, new_addr;
  logic [AW-1:0] pc_out;
  logic [2:0]    ras_count;
  logic          ras_overflow, ras_underflow;

  int n_chk  = 0;
  int n_pass = 0;

  pc_gen_ras #(
    .ADDR_W    (AW),
    .RESET_VEC (RV),
    .STEP      (STEP),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .exc_valid     (exc_valid),
    .exc_vec       (exc_vec),
    .branch_true   (branch_true),
    .new_addr      (new_addr),
    .call_push     (call_push),
    .ret_pop       (ret_pop),
    .pc_out        (pc_out),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            exc;
    logic [AW-1:0] ev;
    bit            st;
    bit            br;
    logic [AW-1:0] na;
    bit            cp;
    bit            rp;
    logic [AW-1:0] pc;
    int            cnt;
    bit            ovf;
    bit            unf;
  } vec_t;

  vec_t tbl[$];

  // Reference model: a plain bounded stack of return addresses.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stk[$];
  bit            m_ovf, m_unf;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [AW-1:0] pc, input int cnt,
                         input bit ovf, input bit unf);
    chk({tag, " pc"}, int'(pc_out), int'(pc));
    chk({tag, " cnt"}, int'(ras_count), cnt);
    chk({tag, " ovf"}, int'(ras_overflow), int'(ovf));
    chk({tag, " unf"}, int'(ras_underflow), int'(unf));
  endtask

  task automatic drive(input bit ex, input logic [AW-1:0] ev, input bit st, input bit br,
                       input logic [AW-1:0] na, input bit cp, input bit rp);
    exc_valid   = ex;
    exc_vec     = ev;
    stall       = st;
    branch_true = br;
    new_addr    = na;
    call_push   = cp;
    ret_pop     = rp;
  endtask

  task automatic model_step(input bit ex, input logic [AW-1:0] ev, input bit st, input bit br,
                            input logic [AW-1:0] na, input bit cp, input bit rp);
    logic [AW-1:0] seq;
    logic [AW-1:0] nxt;
    seq   = m_pc + AW'(STEP);
    m_ovf = 0;
    m_unf = 0;
    if (ex) begin
      m_pc = ev;
      m_stk.delete();
    end else if (!st) begin
      nxt = seq;
      if (br) nxt = na;
      else if (rp) begin
        if (m_stk.size() > 0) nxt = m_stk.pop_back();
        else m_unf = 1;
      end
      if (cp) begin
        if (m_stk.size() == DEPTH) begin
          void'(m_stk.pop_front());
          m_ovf = 1;
        end
        m_stk.push_back(seq);
      end
      m_pc = nxt;
    end
  endtask

  function automatic vec_t v(bit exc, logic [AW-1:0] ev, bit st, bit br, logic [AW-1:0] na,
                             bit cp, bit rp, logic [AW-1:0] pc, int cnt, bit ovf, bit unf);
    vec_t r;
    r = '{exc, ev, st, br, na, cp, rp, pc, cnt, ovf, unf};
    return r;
  endfunction

  initial begin
    //            exc  ev      st br na      cp rp  pc      cnt ovf unf
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 0, 0, 12'h104, 0, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 0, 0, 12'h108, 0, 0, 0));
    // wrap around the top of the address space
    tbl.push_back(v(1, 12'hFFE, 0, 0, 12'h000, 0, 0, 12'hFFE, 0, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 0, 0, 12'h002, 0, 0, 0));
    // stall drops branches, exception still acts
    tbl.push_back(v(0, 12'h000, 1, 1, 12'h300, 0, 0, 12'h002, 0, 0, 0));
    tbl.push_back(v(0, 12'h000, 1, 1, 12'h300, 0, 0, 12'h002, 0, 0, 0));
    tbl.push_back(v(0, 12'h000, 1, 1, 12'h300, 0, 0, 12'h002, 0, 0, 0));
    tbl.push_back(v(1, 12'h040, 1, 1, 12'h300, 0, 0, 12'h040, 0, 0, 0));
    // call at 0x010, branch beats return, then return
    tbl.push_back(v(1, 12'h010, 0, 0, 12'h000, 0, 0, 12'h010, 0, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 1, 0, 12'h014, 1, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 0, 0, 12'h018, 1, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 1, 12'h080, 0, 1, 12'h080, 1, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 0, 1, 12'h014, 0, 0, 0));
    // five pushes (overflow on 5th), five pops (underflow on 5th)
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 1, 0, 12'h018, 1, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 1, 0, 12'h01C, 2, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 1, 0, 12'h020, 3, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 1, 0, 12'h024, 4, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 1, 0, 12'h028, 4, 1, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 0, 1, 12'h028, 3, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 0, 1, 12'h024, 2, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 0, 1, 12'h020, 1, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 0, 1, 12'h01C, 0, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 0, 1, 12'h020, 0, 0, 1));
    // call+return together, non-empty then empty
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 1, 0, 12'h024, 1, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 1, 1, 12'h024, 1, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 0, 1, 12'h028, 0, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 1, 1, 12'h02C, 1, 0, 1));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 0, 1, 12'h02C, 0, 0, 0));
    // stall holds RAS; branch with call still pushes
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 1, 0, 12'h030, 1, 0, 0));
    tbl.push_back(v(0, 12'h000, 1, 0, 12'h000, 1, 1, 12'h030, 1, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 1, 12'h200, 1, 0, 12'h200, 2, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 12'h000, 0, 1, 12'h034, 1, 0, 0));

    rst = 1'b1;
    drive(0, '0, 0, 0, '0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", RV, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].exc, tbl[i].ev, tbl[i].st, tbl[i].br, tbl[i].na, tbl[i].cp, tbl[i].rp);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].cnt, tbl[i].ovf, tbl[i].unf);
    end

    // Async reset mid-operation with three entries and a pending branch.
    drive(1, 12'h050, 0, 0, '0, 0, 0);
    @(posedge clk);
    #1;
    drive(0, '0, 0, 0, '0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_all("pre_rst", 12'h05C, 3, 0, 0);
    drive(0, '0, 0, 1, 12'h3A0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", RV, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_held", RV, 0, 0, 0);
    drive(0, '0, 0, 0, '0, 0, 0);
    rst = 1'b0;
    m_pc = RV;
    m_stk.delete();

    // Randomised run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      bit ex, st, br, cp, rp;
      logic [AW-1:0] ev, na;
      ex = ($urandom_range(0, 29) == 0);
      st = ($urandom_range(0, 7) == 0);
      br = ($urandom_range(0, 7) == 0);
      cp = ($urandom_range(0, 2) == 0);
      rp = ($urandom_range(0, 2) == 0);
      ev = AW'($urandom);
      na = AW'($urandom);
      drive(ex, ev, st, br, na, cp, rp);
      model_step(ex, ev, st, br, na, cp, rp);
      @(posedge clk);
      #1;
      chk_all($sformatf("rnd%0d", i), m_pc, m_stk.size(), m_ovf, m_unf);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
